snitch_regfile_sb: RTL and testbench
====================================

Name: snitch_regfile_sb

Overview:
- Next-generation Snitch integer/FP register file: multi-write-port flip-flop array with asynchronous reset, per-register busy scoreboard and optional write-to-read bypass.
- Sits between issue/decode and the writeback arbiters (ALU, LSU, accelerator).
- Lets the core claim a destination register for a long-latency result (load, offload) and stall readers until the matching writeback releases it.

Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register index width; NUM_WORDS = 2**ADDR_WIDTH
- NR_READ_PORTS, 3, combinational read ports
- NR_WRITE_PORTS, 2, write ports; higher index has priority
- ZERO_REG_ZERO, 1, register 0 hard-wired to zero, never busy
- BYPASS, 1, forward same-cycle write data and release to read ports

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- raddr_i  in  NR_READ_PORTS x ADDR_WIDTH  read addresses
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data
- rbusy_o  out  NR_READ_PORTS  addressed register has a pending claim
- waddr_i  in  NR_WRITE_PORTS x ADDR_WIDTH  write addresses
- wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
- we_i  in  NR_WRITE_PORTS  write enables
- wrel_i  in  NR_WRITE_PORTS  write also releases the busy bit (qualified by we_i)
- claim_valid_i  in  1  request to mark claim_addr_i busy
- claim_addr_i  in  ADDR_WIDTH  register to claim
- claim_ready_o  out  1  claim accepted this cycle
- busy_o  out  NUM_WORDS  full scoreboard vector (registered state)

Behaviour:
- Reset (rst_ni low, asynchronous): all mem words cleared to 0 and all busy bits cleared.
  - Consequences: rdata_o = 0 and rbusy_o = 0, busy_o = 0, claim_ready_o = 1 while reset is held, except under a BYPASS forward.
  - Reset mid-claim discards the pending claim; a later wrel_i to that register is a normal write plus a no-op release.
- Write:
  - On posedge, mem[waddr_i[j]] <= wdata_i[j] for each j with we_i[j].
  - Same address on several ports: the highest j wins.
  - Writes to a non-busy register are legal (no error).
- Zero register (ZERO_REG_ZERO=1):
  - Writes to index 0 are ignored; mem[0] reads 0.
  - busy[0] is never set; claim to 0 is always ready and has no effect.
- Read:
  - Combinational; rdata_o[i] = mem[raddr_i[i]].
  - With BYPASS=1: if any we_i[j] targets raddr_i[i] this cycle, rdata_o[i] = wdata_i of the highest such j. Index 0 is never forwarded when ZERO_REG_ZERO=1.
- Scoreboard:
  - claim_ready_o = !busy[claim_addr_i], independent of claim_valid_i.
  - Accepted claim (valid && ready) sets busy[claim_addr_i] at posedge. Latency 1: busy_o/rbusy_o reflect it next cycle.
  - Release: we_i[j] && wrel_i[j] clears busy[waddr_i[j]] at posedge.
  - rbusy_o[i]:
    - BYPASS=1: busy[raddr_i[i]] && !(same-cycle releasing write to that address).
    - BYPASS=0: busy[raddr_i[i]].
- Simultaneous events:
  - Claim and release to the same register that is busy: claim not ready; release clears; the claim is accepted next cycle.
  - Claim and release to the same register that is not busy: set wins (register ends busy).
  - Two release ports on one address: single clear.
  - wrel_i with we_i low: ignored.
- Widths: no arithmetic. Address compares are full ADDR_WIDTH; all NUM_WORDS entries are implemented.

Decomposition:
- Shared package snitch_regfile_pkg:
  - helper function for highest-priority write-port select
  - localparam computation of NUM_WORDS
- One natural sub-module: snitch_regfile_scoreboard. It holds the busy vector, claim/release logic and claim_ready_o; its release inputs are the per-port decoded write vectors.
- The top level keeps the data array, write decode and bypass muxes.

Test Plan:
- Reset then read: rst_ni low async mid-cycle after writing 0xDEADBEEF to x5 -> rdata_o for x5 = 0 immediately, busy_o = 0.
- Write port priority: same cycle port0 writes x7=0x11, port1 writes x7=0x22 -> next cycle x7 reads 0x22. With BYPASS=1, same-cycle read of x7 returns 0x22.
- Zero register: write x0=0xFFFFFFFF and claim x0 -> x0 reads 0, claim_ready_o = 1, busy_o[0] stays 0.
- Claim/release: claim x10 -> rbusy_o for x10 = 1 next cycle, and a claim of x10 is not ready. Port1 writes x10=0x1234 with wrel_i:
  - BYPASS=1: rbusy_o = 0 and rdata_o = 0x1234 in the same cycle.
  - Next cycle: busy_o[10] = 0.
- Simultaneous claim+release on busy x3 -> claim_ready_o = 0 that cycle, busy_o[3] = 0 next cycle, claim accepted the following cycle, then busy_o[3] = 1.
- Randomised mix of writes, claims and releases against a reference model, including reset asserted mid-stream -> all outputs match every cycle.

Source files
------------

// File: rtl/snitch_regfile_sb_pkg.sv
// Shared types, default sizing and the write-port priority helper for the
// Snitch register file with busy scoreboard.
package snitch_regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_WIDTH     = 5;
  localparam int unsigned DEF_NR_READ_PORTS  = 3;
  localparam int unsigned DEF_NR_WRITE_PORTS = 2;
  localparam int unsigned NUM_WORDS          = 2 ** DEF_ADDR_WIDTH;

  localparam int unsigned WP_IDX_W = (DEF_NR_WRITE_PORTS > 1) ? $clog2(DEF_NR_WRITE_PORTS) : 1;

  // Winning write port for one target: hit flag plus port index.
  typedef struct packed {
    logic                hit;
    logic [WP_IDX_W-1:0] idx;
  } wsel_t;

  // Highest-indexed asserted port wins when several ports target one word.
  function automatic wsel_t pick_write_port(input logic [DEF_NR_WRITE_PORTS-1:0] hits);
    wsel_t r;
    r = '0;
    for (int j = 0; j < DEF_NR_WRITE_PORTS; j++) begin
      if (hits[j]) begin
        r.hit = 1'b1;
        r.idx = WP_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/snitch_regfile_sb_if.sv
// Issue/writeback-side bundle of the register file: read ports, write ports,
// claim handshake and the scoreboard view.
interface snitch_regfile_sb_if import snitch_regfile_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NR_READ_PORTS  = DEF_NR_READ_PORTS,
  parameter int unsigned NR_WRITE_PORTS = DEF_NR_WRITE_PORTS
) ();

  logic [ADDR_WIDTH-1:0]      raddr_i [NR_READ_PORTS];
  logic [DATA_WIDTH-1:0]      rdata_o [NR_READ_PORTS];
  logic [NR_READ_PORTS-1:0]   rbusy_o;
  logic [ADDR_WIDTH-1:0]      waddr_i [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]      wdata_i [NR_WRITE_PORTS];
  logic [NR_WRITE_PORTS-1:0]  we_i;
  logic [NR_WRITE_PORTS-1:0]  wrel_i;
  logic                       claim_valid_i;
  logic [ADDR_WIDTH-1:0]      claim_addr_i;
  logic                       claim_ready_o;
  logic [2**ADDR_WIDTH-1:0]   busy_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, wrel_i, claim_valid_i, claim_addr_i,
    input  rdata_o, rbusy_o, claim_ready_o, busy_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, wrel_i, claim_valid_i, claim_addr_i,
    output rdata_o, rbusy_o, claim_ready_o, busy_o
  );

endinterface

// File: rtl/snitch_regfile_sb_scoreboard.sv
// Busy scoreboard: one bit per register, set by an accepted claim and cleared
// by a releasing writeback. A claim on a busy register is never accepted, so
// the only same-cycle set/clear overlap is on a free register, where set wins.
module snitch_regfile_scoreboard import snitch_regfile_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NR_WRITE_PORTS = DEF_NR_WRITE_PORTS,
  parameter bit          ZERO_REG_ZERO  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     claim_valid_i,
  input  logic [ADDR_WIDTH-1:0]    claim_addr_i,
  input  logic [2**ADDR_WIDTH-1:0] rel_i [NR_WRITE_PORTS],
  output logic                     claim_ready_o,
  output logic [2**ADDR_WIDTH-1:0] busy_o
);

  logic [2**ADDR_WIDTH-1:0] busy_q, busy_d, rel_any;

  assign claim_ready_o = !busy_q[claim_addr_i];
  assign busy_o        = busy_q;

  // Clear released words first, then apply an accepted claim on top.
  always_comb begin
    rel_any = '0;
    for (int j = 0; j < NR_WRITE_PORTS; j++) rel_any = rel_any | rel_i[j];
    busy_d = busy_q & ~rel_any;
    if (claim_valid_i && claim_ready_o && !(ZERO_REG_ZERO && claim_addr_i == '0))
      busy_d[claim_addr_i] = 1'b1;
  end

  // Scoreboard state; reset drops every outstanding claim.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/snitch_regfile_sb.sv
// Multi-write-port flip-flop register file with write-to-read bypass and a
// busy scoreboard for long-latency destinations.
module snitch_regfile_sb import snitch_regfile_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NR_READ_PORTS  = DEF_NR_READ_PORTS,
  parameter int unsigned NR_WRITE_PORTS = DEF_NR_WRITE_PORTS,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter bit          BYPASS         = 1'b1
) (
  input logic                clk_i,
  input logic                rst_ni,
  snitch_regfile_sb_if.slave bus
);

  localparam int unsigned NWORDS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]     mem_q [NWORDS];
  logic [DATA_WIDTH-1:0]     mem_d [NWORDS];
  logic [NR_WRITE_PORTS-1:0] whit  [NWORDS];
  wsel_t                     wsel  [NWORDS];
  logic [NWORDS-1:0]         rel_dec [NR_WRITE_PORTS];
  logic [NR_WRITE_PORTS-1:0] rhit  [NR_READ_PORTS];
  wsel_t                     rsel  [NR_READ_PORTS];
  logic [NWORDS-1:0]         busy;

  // Per-word write decode; word 0 is never a target when hard-wired to zero.
  always_comb begin
    for (int w = 0; w < NWORDS; w++) begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        whit[w][j] = bus.we_i[j] && (bus.waddr_i[j] == ADDR_WIDTH'(w)) &&
                     !(ZERO_REG_ZERO && w == 0);
      end
    end
  end

  // Releasing writes, as one decoded word vector per port for the scoreboard.
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      for (int w = 0; w < NWORDS; w++) begin
        rel_dec[j][w] = whit[w][j] && bus.wrel_i[j];
      end
    end
  end

  // Next array contents with highest-port-wins priority.
  always_comb begin
    for (int w = 0; w < NWORDS; w++) begin
      wsel[w]  = pick_write_port(whit[w]);
      mem_d[w] = wsel[w].hit ? bus.wdata_i[wsel[w].idx] : mem_q[w];
    end
  end

  // Data array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NWORDS; w++) mem_q[w] <= '0;
    end else begin
      for (int w = 0; w < NWORDS; w++) mem_q[w] <= mem_d[w];
    end
  end

  // Same-cycle write hits per read port (all-zero when bypass is disabled).
  always_comb begin
    for (int i = 0; i < NR_READ_PORTS; i++) begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        rhit[i][j] = BYPASS && bus.we_i[j] && (bus.waddr_i[j] == bus.raddr_i[i]) &&
                     !(ZERO_REG_ZERO && bus.raddr_i[i] == '0);
      end
    end
  end

  // Read muxes: forwarded write data first, otherwise the stored word; a
  // same-cycle releasing write also hides the busy bit from the reader.
  always_comb begin
    for (int i = 0; i < NR_READ_PORTS; i++) begin
      rsel[i]        = pick_write_port(rhit[i]);
      bus.rdata_o[i] = rsel[i].hit ? bus.wdata_i[rsel[i].idx] : mem_q[bus.raddr_i[i]];
      bus.rbusy_o[i] = busy[bus.raddr_i[i]] && !(|(rhit[i] & bus.wrel_i));
    end
  end

  assign bus.busy_o = busy;

  snitch_regfile_scoreboard #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .ZERO_REG_ZERO  (ZERO_REG_ZERO)
  ) i_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .claim_valid_i (bus.claim_valid_i),
    .claim_addr_i  (bus.claim_addr_i),
    .rel_i         (rel_dec),
    .claim_ready_o (bus.claim_ready_o),
    .busy_o        (busy)
  );

endmodule

// File: tb/tb_snitch_regfile_sb.sv
// Directed and randomised bench for snitch_regfile_sb against an array/bit-vector
// reference model of the register file and its scoreboard.
module tb_snitch_regfile_sb;
  import snitch_regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;
  localparam int unsigned NW = 2;
  localparam int unsigned NWORDS = NUM_WORDS;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  snitch_regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
                         .NR_WRITE_PORTS(NW)) bus ();

  snitch_regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NR),
                      .NR_WRITE_PORTS(NW), .ZERO_REG_ZERO(1'b1), .BYPASS(1'b1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  logic [DW-1:0]     m_mem [NWORDS];
  logic [NWORDS-1:0] m_busy;
  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NWORDS; w++) m_mem[w] = '0;
    m_busy = '0;
  endtask

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    if (a == '0) return '0;
    r = m_mem[a];
    for (int j = 0; j < NW; j++)
      if (bus.we_i[j] && bus.waddr_i[j] == a) r = bus.wdata_i[j];
    return r;
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    if (!m_busy[a]) return 1'b0;
    for (int j = 0; j < NW; j++)
      if (bus.we_i[j] && bus.wrel_i[j] && bus.waddr_i[j] == a) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clock();
    logic [NWORDS-1:0] nb;
    nb = m_busy;
    for (int j = 0; j < NW; j++) begin
      if (bus.we_i[j] && bus.waddr_i[j] != '0) m_mem[bus.waddr_i[j]] = bus.wdata_i[j];
      if (bus.we_i[j] && bus.wrel_i[j]) nb[bus.waddr_i[j]] = 1'b0;
    end
    if (bus.claim_valid_i && bus.claim_addr_i != '0 && !m_busy[bus.claim_addr_i])
      nb[bus.claim_addr_i] = 1'b1;
    m_busy = nb;
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s.rdata%0d", ctx, i), bus.rdata_o[i], exp_rdata(bus.raddr_i[i]));
      chk($sformatf("%s.rbusy%0d", ctx, i), 32'(bus.rbusy_o[i]), 32'(exp_rbusy(bus.raddr_i[i])));
    end
    chk({ctx, ".claim_ready"}, 32'(bus.claim_ready_o), 32'(!m_busy[bus.claim_addr_i]));
    chk({ctx, ".busy"}, bus.busy_o, m_busy);
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_ni) model_clock();
    @(negedge clk_i);
  endtask

  task automatic idle();
    for (int i = 0; i < NR; i++) bus.raddr_i[i] = '0;
    for (int j = 0; j < NW; j++) begin
      bus.waddr_i[j] = '0;
      bus.wdata_i[j] = '0;
    end
    bus.we_i          = '0;
    bus.wrel_i        = '0;
    bus.claim_valid_i = 1'b0;
    bus.claim_addr_i  = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rel);
    bus.we_i[p]    = 1'b1;
    bus.waddr_i[p] = a;
    bus.wdata_i[p] = d;
    bus.wrel_i[p]  = rel;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NWORDS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic randomize_inputs();
    for (int j = 0; j < NW; j++) begin
      bus.we_i[j]    = 1'($urandom_range(0, 1));
      bus.wrel_i[j]  = 1'($urandom_range(0, 1));
      bus.waddr_i[j] = rnd_addr();
      bus.wdata_i[j] = $urandom;
    end
    for (int i = 0; i < NR; i++) begin
      case ($urandom_range(0, 2))
        0:       bus.raddr_i[i] = bus.waddr_i[0];
        1:       bus.raddr_i[i] = bus.waddr_i[1];
        default: bus.raddr_i[i] = rnd_addr();
      endcase
    end
    bus.claim_valid_i = 1'($urandom_range(0, 1));
    bus.claim_addr_i  = ($urandom_range(0, 2) == 0) ? bus.waddr_i[1] : rnd_addr();
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    check_all("reset");
    chk("reset.ready_const", 32'(bus.claim_ready_o), 32'd1);
    chk("reset.busy_const", bus.busy_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Asynchronous reset after a write to x5.
    wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    idle();
    bus.raddr_i[0] = 5'd5;
    #1;
    chk("x5.written", bus.rdata_o[0], 32'hDEADBEEF);
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("x5.async_rst", bus.rdata_o[0], 32'h0);
    chk("x5.rst_busy", bus.busy_o, 32'h0);
    check_all("async_rst");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write port priority on x7, with bypass.
    wr(0, 5'd7, 32'h11, 1'b0);
    wr(1, 5'd7, 32'h22, 1'b0);
    bus.raddr_i[1] = 5'd7;
    #1;
    chk("prio.bypass", bus.rdata_o[1], 32'h22);
    check_all("prio");
    tick();
    idle();
    bus.raddr_i[1] = 5'd7;
    #1;
    chk("prio.stored", bus.rdata_o[1], 32'h22);

    // Zero register: write and claim are both no-ops.
    wr(0, 5'd0, 32'hFFFFFFFF, 1'b0);
    bus.claim_valid_i = 1'b1;
    bus.claim_addr_i  = 5'd0;
    bus.raddr_i[2]    = 5'd0;
    #1;
    chk("x0.read", bus.rdata_o[2], 32'h0);
    chk("x0.ready", 32'(bus.claim_ready_o), 32'd1);
    tick();
    idle();
    #1;
    chk("x0.busy", 32'(bus.busy_o[0]), 32'd0);
    chk("x0.read_after", bus.rdata_o[0], 32'h0);

    // Claim x10, then release with a port-1 writeback.
    bus.claim_valid_i = 1'b1;
    bus.claim_addr_i  = 5'd10;
    #1;
    check_all("claim10");
    tick();
    idle();
    bus.raddr_i[0]   = 5'd10;
    bus.claim_addr_i = 5'd10;
    #1;
    chk("x10.rbusy", 32'(bus.rbusy_o[0]), 32'd1);
    chk("x10.not_ready", 32'(bus.claim_ready_o), 32'd0);
    wr(1, 5'd10, 32'h1234, 1'b1);
    #1;
    chk("x10.rel_rbusy", 32'(bus.rbusy_o[0]), 32'd0);
    chk("x10.rel_rdata", bus.rdata_o[0], 32'h1234);
    check_all("rel10");
    tick();
    idle();
    #1;
    chk("x10.freed", 32'(bus.busy_o[10]), 32'd0);

    // Claim and release together on busy x3.
    bus.claim_valid_i = 1'b1;
    bus.claim_addr_i  = 5'd3;
    tick();
    wr(0, 5'd3, 32'hA5A5, 1'b1);
    #1;
    chk("x3.ready_low", 32'(bus.claim_ready_o), 32'd0);
    check_all("x3.simul");
    tick();
    bus.we_i   = '0;
    bus.wrel_i = '0;
    #1;
    chk("x3.released", 32'(bus.busy_o[3]), 32'd0);
    chk("x3.ready_high", 32'(bus.claim_ready_o), 32'd1);
    tick();
    idle();
    #1;
    chk("x3.reclaimed", 32'(bus.busy_o[3]), 32'd1);
    check_all("x3.end");

    // Random mix, with occasional asynchronous reset mid-cycle.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      #1;
      check_all($sformatf("rnd%0d", c));
      if ($urandom_range(0, 40) == 0) begin
        #1;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all($sformatf("rnd%0d.rst", c));
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
